mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset; while 0, all state is held at its reset value.
REQ-003 SHALL have port MADOP, input, 4 bits: operation code from the decoder, valid in the E stage. Encoding: 0 = none, 1 = MULT, 2 = MULTU, 3 = MTHI, 4 = MTLO, 5 = DIV, 6 = DIVU, 7..15 = none.
REQ-004 SHALL have port Req, input, 1 bit: an exception or interrupt is being taken this cycle; when 1, suppresses any start or write presented in the same cycle.
REQ-005 SHALL have port A, input, 32 bits: rs operand (forwarded); also the MTHI/MTLO data.
REQ-006 SHALL have port B, input, 32 bits: rt operand (forwarded).
REQ-007 SHALL have port Start, output, 1 bit, combinational: 1 when MADOP is in {1,2,5,6}, Req = 0 and the unit is IDLE.
REQ-008 SHALL have port Busy, output, 1 bit, registered: 1 while an operation is in flight.
REQ-009 SHALL have port HI, output, 32 bits, registered: architectural HI.
REQ-010 SHALL have port LO, output, 32 bits, registered: architectural LO.

Function
REQ-011 SHALL implement a two-state FSM, IDLE and BUSY, with a 4-bit down-counter cnt.
REQ-012 IDLE to BUSY: on a clock edge where Start = 1. Load cnt = 5 for MULT/MULTU and cnt = 10 for DIV/DIVU. Capture the computed result into internal registers hi_tmp and lo_tmp. Leave HI/LO unchanged.
REQ-013 In BUSY, cnt SHALL decrement by 1 each cycle. At the edge where cnt = 1, HI <= hi_tmp, LO <= lo_tmp, Busy <= 0 and the FSM returns to IDLE.
REQ-014 Timing: with Start at cycle n, Busy SHALL be 1 in cycles n+1..n+5 for multiply and n+1..n+10 for divide. New HI/LO SHALL be visible from cycle n+6 (multiply) or n+11 (divide).
REQ-015 MULT SHALL form the signed 64-bit product of A*B; MULTU the unsigned product. HI = bits 63:32, LO = bits 31:0.
REQ-016 DIV (signed): LO = quotient truncated toward zero, HI = remainder with the sign of the dividend A. DIVU: unsigned quotient and remainder.
REQ-017 DIV with A = 0x80000000 and B = 0xFFFFFFFF SHALL give LO = 0x80000000, HI = 0x00000000.
REQ-018 Divide by zero (B = 0) SHALL still run the full 10-cycle BUSY sequence, leaving HI and LO unchanged at completion.
REQ-019 MTHI/MTLO: in IDLE with Req = 0, HI or LO <= A at the next edge, 1-cycle latency, Busy stays 0.
REQ-020 MADOP in {1..6} while BUSY SHALL be ignored; the decoder's stall logic (InsrtMAD & (Start | Busy)) guarantees none arrive.
REQ-021 Req = 1 with MADOP in {1..6} SHALL leave FSM, cnt, HI and LO unchanged.
REQ-022 Req = 1 while BUSY SHALL NOT cancel the operation; it completes per REQ-013.
REQ-023 MADOP values 7..15 SHALL have no effect in any state.

Reset
REQ-024 On reset = 0 at any time, including mid-operation, the unit SHALL asynchronously force state = IDLE, cnt = 0, Busy = 0, HI = 0, LO = 0, hi_tmp = 0, lo_tmp = 0. The pending result is discarded.
REQ-025 After reset deasserts, the first edge SHALL accept a new operation normally.

Verification
REQ-026 MULT, A = 0xFFFFFFFE (-2), B = 3 at cycle 0: Start = 1; Busy = 1 in cycles 1-5; from cycle 6 HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
REQ-027 MULTU, A = 0xFFFFFFFF, B = 0xFFFFFFFF: after 5 busy cycles HI = 0xFFFFFFFE, LO = 0x00000001.
REQ-028 DIV, A = -7 (0xFFFFFFF9), B = 2: Busy for 10 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU with B = 0 leaves prior HI/LO after 10 busy cycles.
REQ-029 MTHI A = 0x12345678, then MTLO A = 0x9ABCDEF0 on consecutive cycles: HI and LO update one cycle each, Busy never asserts.
REQ-030 DIV issued with Req = 1: Start = 0, Busy stays 0, HI/LO unchanged. MULT started, then Req = 1 at cycle 2: result still lands at cycle 6.
REQ-031 Reset pulled low at cycle 3 of a DIV: Busy, HI and LO read 0 immediately (no clock edge needed), and no later write occurs.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multiply/divide unit for the E stage: owns architectural HI/LO.
// MULT/MULTU run 5 busy cycles and DIV/DIVU run 10. The result is computed
// at start, parked in hi_tmp/lo_tmp, and committed to HI/LO when the down-counter
// expires. MTHI/MTLO write HI or LO directly with one cycle of latency.
module mult_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  MADOP,
   input  logic        Req,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Start,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_MTHI  = 4'd3;
   localparam logic [3:0] OP_MTLO  = 4'd4;
   localparam logic [3:0] OP_DIV   = 4'd5;
   localparam logic [3:0] OP_DIVU  = 4'd6;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t      r_state, w_state_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic        r_busy, w_busy_nxt;
   logic [31:0] r_hi, w_hi_nxt, r_lo, w_lo_nxt;
   logic [31:0] r_hi_tmp, w_hi_tmp_nxt, r_lo_tmp, w_lo_tmp_nxt;

   logic        w_is_mul, w_is_div;
   logic [63:0] w_a_sx, w_b_sx, w_mul_s, w_mul_u;
   logic        w_a_neg, w_b_neg, w_b_zero;
   logic [31:0] w_a_mag, w_b_mag, w_sden, w_uden;
   logic [31:0] w_sq_mag, w_sr_mag, w_sq, w_sr, w_uq, w_ur;
   logic [31:0] w_res_hi, w_res_lo;

   assign w_is_mul = (MADOP == OP_MULT) || (MADOP == OP_MULTU);
   assign w_is_div = (MADOP == OP_DIV)  || (MADOP == OP_DIVU);
   assign Start    = (w_is_mul || w_is_div) && !Req && (r_state == S_IDLE);

   // Products: the low 64 bits of a 64x64 product of sign-extended operands is the signed product
   assign w_a_sx  = {{32{A[31]}}, A};
   assign w_b_sx  = {{32{B[31]}}, B};
   assign w_mul_s = w_a_sx * w_b_sx;
   assign w_mul_u = {32'd0, A} * {32'd0, B};

   // Signed divide via magnitudes, so 0x80000000 / -1 wraps to 0x80000000 with remainder 0
   assign w_a_neg  = A[31];
   assign w_b_neg  = B[31];
   assign w_b_zero = (B == 32'd0);
   assign w_a_mag  = w_a_neg ? (~A + 32'd1) : A;
   assign w_b_mag  = w_b_neg ? (~B + 32'd1) : B;
   assign w_sden   = w_b_zero ? 32'd1 : w_b_mag;
   assign w_uden   = w_b_zero ? 32'd1 : B;
   assign w_sq_mag = w_a_mag / w_sden;
   assign w_sr_mag = w_a_mag % w_sden;
   assign w_sq     = (w_a_neg ^ w_b_neg) ? (~w_sq_mag + 32'd1) : w_sq_mag;
   assign w_sr     = w_a_neg ? (~w_sr_mag + 32'd1) : w_sr_mag;
   assign w_uq     = A / w_uden;
   assign w_ur     = A % w_uden;

   // Select the result to park; a divide by zero parks the current HI/LO so completion is a no-op
   always_comb begin
      w_res_hi = r_hi;
      w_res_lo = r_lo;
      case (MADOP)
         OP_MULT:  begin w_res_hi = w_mul_s[63:32]; w_res_lo = w_mul_s[31:0]; end
         OP_MULTU: begin w_res_hi = w_mul_u[63:32]; w_res_lo = w_mul_u[31:0]; end
         OP_DIV: begin
            if (w_b_zero) begin w_res_hi = r_hi; w_res_lo = r_lo; end
            else          begin w_res_hi = w_sr; w_res_lo = w_sq; end
         end
         OP_DIVU: begin
            if (w_b_zero) begin w_res_hi = r_hi; w_res_lo = r_lo; end
            else          begin w_res_hi = w_ur; w_res_lo = w_uq; end
         end
         default: begin w_res_hi = r_hi; w_res_lo = r_lo; end
      endcase
   end

   // Next-state logic: start/MTHI/MTLO in IDLE, countdown and commit in BUSY
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_busy_nxt   = r_busy;
      w_hi_nxt     = r_hi;
      w_lo_nxt     = r_lo;
      w_hi_tmp_nxt = r_hi_tmp;
      w_lo_tmp_nxt = r_lo_tmp;
      case (r_state)
         S_IDLE: begin
            if (Start) begin
               w_state_nxt  = S_BUSY;
               w_busy_nxt   = 1'b1;
               w_cnt_nxt    = w_is_div ? 4'd10 : 4'd5;
               w_hi_tmp_nxt = w_res_hi;
               w_lo_tmp_nxt = w_res_lo;
            end else if (!Req && (MADOP == OP_MTHI)) begin
               w_hi_nxt = A;
            end else if (!Req && (MADOP == OP_MTLO)) begin
               w_lo_nxt = A;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_BUSY: begin
            if (r_cnt == 4'd1) begin
               w_state_nxt = S_IDLE;
               w_busy_nxt  = 1'b0;
               w_cnt_nxt   = 4'd0;
               w_hi_nxt    = r_hi_tmp;
               w_lo_nxt    = r_lo_tmp;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   // State registers; reset discards any pending result
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= 4'd0;
         r_busy   <= 1'b0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
         r_hi_tmp <= 32'd0;
         r_lo_tmp <= 32'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_busy   <= w_busy_nxt;
         r_hi     <= w_hi_nxt;
         r_lo     <= w_lo_nxt;
         r_hi_tmp <= w_hi_tmp_nxt;
         r_lo_tmp <= w_lo_tmp_nxt;
      end
   end

   assign Busy = r_busy;
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule
